// File: rtl/morse_pkg.sv
// Shared definitions for the Morse link: character codes, timing multipliers and
// the encoder state encoding.
package morse_pkg;

    localparam logic [5:0] CH_0         = 6'd0;
    localparam logic [5:0] CH_A         = 6'd10;
    localparam logic [5:0] CH_SPACE     = 6'd36;
    localparam logic [5:0] CH_MAX_VALID = 6'd36;

    localparam int unsigned DOT_U      = 1;
    localparam int unsigned DASH_U     = 3;
    localparam int unsigned ELEM_GAP_U = 1;
    localparam int unsigned CHAR_GAP_U = 3;
    localparam int unsigned WORD_GAP_U = 7;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StGap,
        StCharGap,
        StWordGap,
        StErr
    } state_e;

endpackage

// File: rtl/morse_rom.sv
// Character code to Morse element table. pat is sent LSB first; 1 = dash, 0 = dot.
// Codes outside 0-35 return len 0.
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] code,
    output logic [2:0] len,
    output logic [4:0] pat
);

    always_comb begin
        len = 3'd0;
        pat = 5'b00000;
        case (code)
            6'd0:  begin len = 3'd5; pat = 5'b11111; end
            6'd1:  begin len = 3'd5; pat = 5'b11110; end
            6'd2:  begin len = 3'd5; pat = 5'b11100; end
            6'd3:  begin len = 3'd5; pat = 5'b11000; end
            6'd4:  begin len = 3'd5; pat = 5'b10000; end
            6'd5:  begin len = 3'd5; pat = 5'b00000; end
            6'd6:  begin len = 3'd5; pat = 5'b00001; end
            6'd7:  begin len = 3'd5; pat = 5'b00011; end
            6'd8:  begin len = 3'd5; pat = 5'b00111; end
            6'd9:  begin len = 3'd5; pat = 5'b01111; end
            6'd10: begin len = 3'd2; pat = 5'b00010; end // A
            6'd11: begin len = 3'd4; pat = 5'b00001; end
            6'd12: begin len = 3'd4; pat = 5'b00101; end
            6'd13: begin len = 3'd3; pat = 5'b00001; end
            6'd14: begin len = 3'd1; pat = 5'b00000; end
            6'd15: begin len = 3'd4; pat = 5'b00100; end
            6'd16: begin len = 3'd3; pat = 5'b00011; end
            6'd17: begin len = 3'd4; pat = 5'b00000; end
            6'd18: begin len = 3'd2; pat = 5'b00000; end
            6'd19: begin len = 3'd4; pat = 5'b01110; end
            6'd20: begin len = 3'd3; pat = 5'b00101; end
            6'd21: begin len = 3'd4; pat = 5'b00010; end
            6'd22: begin len = 3'd2; pat = 5'b00011; end
            6'd23: begin len = 3'd2; pat = 5'b00001; end
            6'd24: begin len = 3'd3; pat = 5'b00111; end
            6'd25: begin len = 3'd4; pat = 5'b00110; end
            6'd26: begin len = 3'd4; pat = 5'b01011; end
            6'd27: begin len = 3'd3; pat = 5'b00010; end
            6'd28: begin len = 3'd3; pat = 5'b00000; end
            6'd29: begin len = 3'd1; pat = 5'b00001; end
            6'd30: begin len = 3'd3; pat = 5'b00100; end
            6'd31: begin len = 3'd4; pat = 5'b01000; end
            6'd32: begin len = 3'd3; pat = 5'b00110; end
            6'd33: begin len = 3'd4; pat = 5'b01001; end
            6'd34: begin len = 3'd4; pat = 5'b01101; end
            6'd35: begin len = 3'd4; pat = 5'b00011; end // Z
            default: begin len = 3'd0; pat = 5'b00000; end
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: accepts one character per valid/ready handshake and keys it
// out on key_out with a square-wave buzzer tone during marks.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 12_500_000,
    parameter int unsigned TONE_DIV    = 25_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] char_in,
    input  logic       valid,
    output logic       ready,
    output logic       key_out,
    output logic       buzzer,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CW = $clog2(WORD_GAP_U * UNIT_CYCLES);
    localparam int unsigned TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [CW-1:0] DOT_END  = CW'(DOT_U * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_END = CW'(DASH_U * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(ELEM_GAP_U * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CHAR_END = CW'(CHAR_GAP_U * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] WORD_END = CW'(WORD_GAP_U * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] TONE_END = TW'(TONE_DIV - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tone_q, tone_d;
    logic [2:0]    elem_q, elem_d;
    logic [5:0]    char_q, char_d;

    logic ready_q, ready_d;
    logic key_q, key_d;
    logic buzz_q, buzz_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;
    logic [CW-1:0] mark_end;
    logic          last_elem;

    morse_rom u_rom (
        .code (char_q),
        .len  (rom_len),
        .pat  (rom_pat)
    );

    assign mark_end  = rom_pat[elem_q] ? DASH_END : DOT_END;
    assign last_elem = (elem_q == rom_len - 3'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        elem_d  = elem_q;
        char_d  = char_q;

        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    char_d = char_in;
                    cnt_d  = '0;
                    elem_d = 3'd0;
                    if (char_in < CH_SPACE) begin
                        state_d = StMark;
                    end else if (char_in == CH_SPACE) begin
                        state_d = StWordGap;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StMark: begin
                if (cnt_q == mark_end) begin
                    cnt_d   = '0;
                    state_d = last_elem ? StCharGap : StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    elem_d  = elem_q + 3'd1;
                    state_d = StMark;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCharGap: begin
                if (cnt_q == CHAR_END) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWordGap: begin
                if (cnt_q == WORD_END) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        tone_d  = '0;
        buzz_d  = 1'b0;
        ready_d = (state_d == StIdle);
        key_d   = (state_d == StMark);
        err_d   = (state_d == StErr);
        done_d  = ((state_d == StCharGap) && (cnt_d == CHAR_END)) ||
                  ((state_d == StWordGap) && (cnt_d == WORD_END));

        if (state_d == StMark) begin
            if (state_q != StMark) begin
                buzz_d = 1'b1;
            end else if (tone_q == TONE_END) begin
                buzz_d = ~buzz_q;
            end else begin
                tone_d = tone_q + 1'b1;
                buzz_d = buzz_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tone_q  <= '0;
            elem_q  <= 3'd0;
            char_q  <= 6'd0;
            ready_q <= 1'b1;
            key_q   <= 1'b0;
            buzz_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            elem_q  <= elem_d;
            char_q  <= char_d;
            ready_q <= ready_d;
            key_q   <= key_d;
            buzz_q  <= buzz_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = ~ready_q;
    assign key_out = key_q;
    assign buzzer  = buzz_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Cycle-accurate scoreboard bench for morse_encoder with UNIT_CYCLES=4, TONE_DIV=2.
module tb_morse_encoder;

    localparam int U  = 4;
    localparam int TD = 2;

    typedef logic [5:0] vec_t; // {ready, busy, key_out, buzzer, done, err}

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] char_in;
    logic       valid;
    logic       ready, key_out, buzzer, busy, done, err;

    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    string tbl [36] = '{
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    always #5 clk = ~clk;

    morse_encoder #(
        .UNIT_CYCLES (U),
        .TONE_DIV    (TD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .char_in (char_in),
        .valid   (valid),
        .ready   (ready),
        .key_out (key_out),
        .buzzer  (buzzer),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    function automatic vec_t observe();
        return {ready, busy, key_out, buzzer, done, err};
    endfunction

    task automatic check(input string tag, input vec_t got, input vec_t want);
        checks++;
        assert (got === want)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (ready,busy,key,buzz,done,err)",
                   tag, got, want);
        end
    endtask

    // Expected output vectors for every cycle after acceptance, ending in one idle cycle.
    task automatic push_char(input int ch);
        string s;
        int    n;
        if (ch < 36) begin
            s = tbl[ch];
            for (int e = 0; e < s.len(); e++) begin
                n = (s.getc(e) == "-") ? 3 * U : U;
                for (int i = 0; i < n; i++)
                    exp_q.push_back({1'b0, 1'b1, 1'b1, ((i / TD) % 2 == 0), 1'b0, 1'b0});
                if (e < s.len() - 1)
                    for (int i = 0; i < U; i++) exp_q.push_back(6'b010000);
            end
            for (int i = 0; i < 3 * U; i++)
                exp_q.push_back((i == 3 * U - 1) ? 6'b010010 : 6'b010000);
        end else if (ch == 36) begin
            for (int i = 0; i < 7 * U; i++)
                exp_q.push_back((i == 7 * U - 1) ? 6'b010010 : 6'b010000);
        end else begin
            exp_q.push_back(6'b010001);
        end
        exp_q.push_back(6'b100000);
    endtask

    // Called at a negedge; compares one entry per cycle, at most max_n entries.
    task automatic run_queue(input string tag, input int drop_at, input int max_n);
        int idx = 0;
        while (exp_q.size() > 0 && idx < max_n) begin
            vec_t w = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, idx), observe(), w);
            if (idx == drop_at) valid = 1'b0;
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic send(input string tag, input int ch);
        valid   = 1'b1;
        char_in = 6'(ch);
        push_char(ch);
        @(negedge clk);
        valid   = 1'b0;
        char_in = 6'd63;
        run_queue(tag, -1, 100000);
    endtask

    initial begin
        int n;
        rst     = 1'b0;
        valid   = 1'b0;
        char_in = 6'd0;
        #12;
        check("reset", observe(), 6'b100000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", observe(), 6'b100000);

        send("E", 14);

        // Valid held high: invalid code offered during 'A' is ignored until ready returns.
        valid   = 1'b1;
        char_in = 6'd10;
        push_char(10);
        n = exp_q.size();
        push_char(40);
        @(negedge clk);
        char_in = 6'd40;
        run_queue("A_then_40", n, 100000);

        send("ZERO", 0);
        send("SPACE", 36);
        send("INV", 40);
        send("Q", 26);
        send("SEVEN", 7);
        send("Z", 35);

        // Abort in the middle of the dash of 'T'.
        valid   = 1'b1;
        char_in = 6'd29;
        push_char(29);
        @(negedge clk);
        valid = 1'b0;
        run_queue("T", -1, 6);
        rst = 1'b0;
        #1;
        check("reset_mid_dash", observe(), 6'b100000);
        exp_q.delete();
        @(negedge clk);
        check("reset_held", observe(), 6'b100000);
        rst = 1'b1;
        @(negedge clk);
        send("E_after_reset", 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
